// File: rtl/and_mux_pkg.sv
// Shared types and constants for the mux-as-AND sequential reducer.
// Lane indices select the three accumulator variants inside the top.
package and_mux_pkg;

  localparam int DATA_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int LANE_GOOD = 0;
  localparam int LANE_ONE  = 1;
  localparam int LANE_SWAP = 2;
  localparam int NUM_LANES = 3;

endpackage

// File: rtl/and_mux_seq_reducer_if.sv
// Beat input and result output bundle of the reducer.
// Handshake: a beat transfers on a clk edge where in_valid && in_ready; a result
// transfers where out_valid && out_ready; producers hold data stable while valid.
interface and_mux_seq_reducer_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_first;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] y_good;
  logic [DATA_W-1:0] y_bad_one;
  logic [DATA_W-1:0] y_bad_swap;
  logic [CNT_W-1:0]  beat_count;
  logic              overflow;

  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, out_valid, y_good, y_bad_one, y_bad_swap, beat_count, overflow
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, out_valid, y_good, y_bad_one, y_bad_swap, beat_count, overflow
  );
endinterface

// File: rtl/mux_acc_lane.sv
// One accumulator lane: per-bit registered 2:1 mux feeding back on itself,
// plus a result register captured on frame close.
module mux_acc_lane #(
  parameter int   DATA_W    = 4,
  parameter logic CONST_VAL = 1'b0,
  parameter bit   ARM_SWAP  = 1'b0
) (
  input  logic              clk,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] mux_w;

  // Kept as a literal ternary per bit so the mux stays visible in the feedback path.
  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    if (ARM_SWAP) begin : g_swap
      assign mux_w[i] = acc_q[i] ? CONST_VAL : d_i[i];
    end else begin : g_norm
      assign mux_w[i] = acc_q[i] ? d_i[i] : CONST_VAL;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = d_i;
    end else if (step_i) begin
      acc_d = mux_w;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (capture_i) begin
        y_q <= acc_d;
      end
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/and_mux_seq_reducer.sv
// Framed multi-beat reducer with three mux-in-feedback lanes (AND-via-mux,
// constant-1 and swapped-arm); results are held until the consumer accepts them.
module and_mux_seq_reducer
  import and_mux_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  and_mux_seq_reducer_if.slave bus,
  output logic [1:0] dbg_state_o
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_HOLD  = HOLD;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic accept, load, step, close, capture, release_w;
  logic [DATA_W-1:0] y_lane [NUM_LANES];

  assign bus.in_ready  = rst_n && (state_q != ST_HOLD);
  assign bus.out_valid = rst_n && (state_q == ST_HOLD);

  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    // A first beat restarts the frame from IDLE or mid-frame alike.
    load      = accept && bus.in_first && (state_q != ST_HOLD);
    step      = accept && !bus.in_first && (state_q == ST_ACCUM);
    release_w = bus.out_valid && bus.out_ready;

    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(1);
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    close   = bus.in_last || (cnt_d == CNT_MAX);
    capture = (load || step) && close;

    state_d = state_q;
    ovf_d   = ovf_q;
    if (capture) begin
      state_d = ST_HOLD;
      ovf_d   = !bus.in_last;
    end else if (load) begin
      state_d = ST_ACCUM;
      ovf_d   = 1'b0;
    end else if (release_w) begin
      state_d = ST_IDLE;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  mux_acc_lane #(.DATA_W(DATA_W), .CONST_VAL(1'b0), .ARM_SWAP(1'b0)) u_lane_good (
    .clk       (clk),
    .clear_i   (!rst_n),
    .load_i    (load),
    .step_i    (step),
    .capture_i (capture),
    .d_i       (bus.in_data),
    .y_o       (y_lane[LANE_GOOD])
  );

  mux_acc_lane #(.DATA_W(DATA_W), .CONST_VAL(1'b1), .ARM_SWAP(1'b0)) u_lane_one (
    .clk       (clk),
    .clear_i   (!rst_n),
    .load_i    (load),
    .step_i    (step),
    .capture_i (capture),
    .d_i       (bus.in_data),
    .y_o       (y_lane[LANE_ONE])
  );

  mux_acc_lane #(.DATA_W(DATA_W), .CONST_VAL(1'b0), .ARM_SWAP(1'b1)) u_lane_swap (
    .clk       (clk),
    .clear_i   (!rst_n),
    .load_i    (load),
    .step_i    (step),
    .capture_i (capture),
    .d_i       (bus.in_data),
    .y_o       (y_lane[LANE_SWAP])
  );

  assign bus.y_good     = y_lane[LANE_GOOD];
  assign bus.y_bad_one  = y_lane[LANE_ONE];
  assign bus.y_bad_swap = y_lane[LANE_SWAP];
  assign bus.beat_count = cnt_q;
  assign bus.overflow   = ovf_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_and_mux_seq_reducer.sv
// Directed bench for and_mux_seq_reducer with hand-computed lane results.
module tb_and_mux_seq_reducer;

  localparam int DATA_W = 4;
  localparam int MAX_BEATS = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  int checks;
  int failures;

  and_mux_seq_reducer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  and_mux_seq_reducer #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one beat for exactly one edge
  task automatic send_beat(input logic [3:0] d, input logic first, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_first = first;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 4'hx;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.overflow} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {bus.out_valid, bus.in_ready, bus.overflow});
    end
    checks++;
    if ({bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0000", {bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count});
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    send_beat(4'b1111, 1'b1, 1'b0);
    send_beat(4'b1010, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid);
    end
    send_beat(4'b0110, 1'b0, 1'b1);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.overflow} !== 3'b100) begin
      failures++;
      $display("FAIL basic_flags got=%b exp=100", {bus.out_valid, bus.in_ready, bus.overflow});
    end
    checks++;
    if ({bus.y_good, bus.y_bad_one, bus.y_bad_swap} !== 12'b0010_0111_0110) begin
      failures++;
      $display("FAIL basic_y got=%b exp=001001110110", {bus.y_good, bus.y_bad_one, bus.y_bad_swap});
    end
    checks++;
    if (bus.beat_count !== 4'd3) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=3", bus.beat_count);
    end
    release_result();
    checks++;
    if ({bus.out_valid, bus.in_ready, dbg_state} !== 4'b0100) begin
      failures++;
      $display("FAIL basic_release got=%b exp=0100", {bus.out_valid, bus.in_ready, dbg_state});
    end
    checks++;
    if ({bus.y_good, bus.beat_count} !== 8'b0010_0011) begin
      failures++;
      $display("FAIL basic_keep got=%b exp=00100011", {bus.y_good, bus.beat_count});
    end
  endtask

  task automatic test_single_hold();
    send_beat(4'b1001, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count}
          !== {2'b10, 12'b1001_1001_1001, 4'd1}) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got=%b exp=10100110011001_0001", i,
                 {bus.out_valid, bus.in_ready, bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count});
      end
      tick();
    end
    release_result();
  endtask

  task automatic test_overflow();
    send_beat(4'b1111, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) send_beat(4'b1111, 1'b0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.beat_count} !== {1'b0, 4'd7}) begin
      failures++;
      $display("FAIL ovf_before got=%b exp=00111", {bus.out_valid, bus.beat_count});
    end
    send_beat(4'b1111, 1'b0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.overflow, bus.beat_count} !== {2'b11, 4'd8}) begin
      failures++;
      $display("FAIL ovf_close got=%b exp=111000", {bus.out_valid, bus.overflow, bus.beat_count});
    end
    checks++;
    if ({bus.y_good, bus.y_bad_one, bus.y_bad_swap} !== 12'b1111_1111_0000) begin
      failures++;
      $display("FAIL ovf_y got=%b exp=111111110000", {bus.y_good, bus.y_bad_one, bus.y_bad_swap});
    end
    release_result();
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
    end
  endtask

  task automatic test_restart();
    send_beat(4'b0000, 1'b1, 1'b0);
    send_beat(4'b1100, 1'b1, 1'b0);
    send_beat(4'b1000, 1'b0, 1'b1);
    checks++;
    if ({bus.out_valid, bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count}
        !== {1'b1, 12'b1000_1011_0000, 4'd2}) begin
      failures++;
      $display("FAIL restart got=%b exp=1100010110000_0010",
               {bus.out_valid, bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count});
    end
    release_result();
  endtask

  task automatic test_drop_and_reset();
    send_beat(4'b0101, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.out_valid, dbg_state, bus.beat_count} !== {3'b000, 4'd2}) begin
      failures++;
      $display("FAIL drop got=%b exp=0000010", {bus.out_valid, dbg_state, bus.beat_count});
    end
    send_beat(4'b1111, 1'b1, 1'b0);
    send_beat(4'b1010, 1'b0, 1'b0);
    checks++;
    if (dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL midframe_state got=%0d exp=1", dbg_state);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({bus.out_valid, bus.overflow, dbg_state, bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count}
        !== 20'h0) begin
      failures++;
      $display("FAIL midframe_reset got=%b exp=0",
               {bus.out_valid, bus.overflow, dbg_state, bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    send_beat(4'b1100, 1'b1, 1'b0);
    send_beat(4'b0100, 1'b0, 1'b1);
    checks++;
    if ({bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count} !== {12'b0100_0111_0000, 4'd2}) begin
      failures++;
      $display("FAIL b2b_first got=%b exp=0100011100000010",
               {bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count});
    end
    // Next frame's beat is already offered while the result handshake happens.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0011;
    bus.in_first  = 1'b1;
    bus.in_last   = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, dbg_state, bus.in_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_handshake got=%b exp=0001", {bus.out_valid, dbg_state, bus.in_ready});
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    checks++;
    if ({bus.out_valid, bus.overflow, bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count}
        !== {2'b10, 12'b0011_0011_0011, 4'd1}) begin
      failures++;
      $display("FAIL b2b_second got=%b exp=10001100110011_0001",
               {bus.out_valid, bus.overflow, bus.y_good, bus.y_bad_one, bus.y_bad_swap, bus.beat_count});
    end
    release_result();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_single_hold();
    test_overflow();
    test_restart();
    test_drop_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/and_mux_seq_reducer.md
Name: and_mux_seq_reducer

Overview:
- Sequential companion fixture for the mux-as-AND pattern family. It consumes framed multi-beat data and reduces it through registered per-bit 2:1 muxes.
- Three reduction lanes run in parallel:
  - one true AND-via-mux (1'b0 on the false arm);
  - one constant-1 variant;
  - one arm-swapped variant.
- It gives the pattern matcher positive and negative matches where the mux sits in a register feedback path, not in pure combinational logic.
- Results are returned with a valid/ready handshake.

Parameters:
- DATA_W, 4, width of each data beat and of each accumulator lane.
- MAX_BEATS, 8, maximum beats per frame before forced close; must be >= 1.
- CNT_W, $clog2(MAX_BEATS+1), width of the beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  beat data.
- in_first  in  1  beat starts a frame.
- in_last  in  1  beat ends a frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y_good  out  DATA_W  AND-via-mux reduction.
- y_bad_one  out  DATA_W  constant-1 variant reduction.
- y_bad_swap  out  DATA_W  swapped-arm variant reduction.
- beat_count  out  CNT_W  beats accepted in the frame.
- overflow  out  1  frame force-closed at MAX_BEATS without in_last.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE.
  - Accumulators, y_* and beat_count = 0.
  - out_valid=0, overflow=0, in_ready=0 during the reset cycle.
- FSM states: IDLE, ACCUM, HOLD.
  - in_ready = (state != HOLD).
  - out_valid = (state == HOLD).
- Accept event: in_valid && in_ready.
- IDLE:
  - Accepted beats without in_first are dropped.
  - An accepted beat with in_first loads all three accumulators with in_data and sets beat_count=1.
  - If that beat also has in_last, go to HOLD. Otherwise go to ACCUM.
- ACCUM, accepted beat without in_first, per bit i (acc = previous value, d = in_data):
  - good[i]  <= acc_good[i] ? d[i] : 1'b0
  - one[i]   <= acc_one[i]  ? d[i] : 1'b1
  - swap[i]  <= acc_swap[i] ? 1'b0 : d[i]
  - beat_count increments.
  - Each lane must be written as an explicit ternary mux, not simplified logic.
- ACCUM, accepted beat with in_first: the frame restarts. Accumulators reload from in_data, beat_count=1, overflow=0.
- Frame close, go to HOLD when either:
  - an accepted beat has in_last; or
  - the accepted beat brings beat_count to MAX_BEATS. This sets overflow=1 unless in_last is also set.
- Results: y_* are registered copies of the accumulators, updated in the same cycle as the final accumulation. out_valid rises in the cycle after the closing beat (1-cycle latency).
- HOLD:
  - in_ready=0; y_*, beat_count and overflow are held stable.
  - When out_valid && out_ready: go to IDLE; overflow clears. y_* and beat_count keep their values.
- Gaps: in_valid=0 in ACCUM holds state with no timeout.
- Reset mid-frame or in HOLD: discards the frame and returns all outputs to reset values next cycle.
- in_data is don't-care when in_valid=0.

Decomposition:
- Package and_mux_pkg holds:
  - state enum typedef (IDLE, ACCUM, HOLD);
  - lane index constants LANE_GOOD, LANE_ONE, LANE_SWAP;
  - shared default DATA_W.
- One natural sub-module: mux_acc_lane. Parameters are DATA_W and the constant value and arm position for the mux. It has load/step/clear inputs and is instantiated three times.

Test Plan:
- DATA_W=4, frame 1111(first), 1010, 0110(last) -> y_good=0010, y_bad_one=0111, y_bad_swap=0110, beat_count=3, overflow=0, out_valid 1 cycle after last beat.
- Single beat 1001 with first&last -> all three y=1001, beat_count=1; hold with out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- MAX_BEATS=8: 8 beats of 1111 with no last -> HOLD, overflow=1, beat_count=8, y_good=1111, y_bad_one=1111, y_bad_swap=0000 (alternates each beat, even count gives 0000).
- ACCUM with 0000, then a new first beat 1100, then last 1000 -> restart; y_good=1000, beat_count=2.
- Beat without first in IDLE (data 0101) -> ignored, out_valid stays 0; rst_n=0 mid-frame -> next cycle all outputs 0, state IDLE.
- Back-to-back frames with out_ready=1 -> second frame's first beat accepted in the cycle after the handshake; results independent of the previous frame.
